// File: rtl/clk_sw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_sw_pkg
//  Description : Shared types, source encodings and helpers for the clock
//                switch control stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_sw_pkg;

    // Control FSM states, explicitly encoded on two bits
    typedef enum logic [1:0] {
        c_ST_IDLE     = 2'd0,
        c_ST_CHECK    = 2'd1,
        c_ST_SETTLE   = 2'd2,
        c_ST_FALLBACK = 2'd3
    } clk_sw_state_e;

    // Clock mux source encodings
    localparam logic [1:0] c_SRC0 = 2'b00;
    localparam logic [1:0] c_SRC1 = 2'b01;
    localparam logic [1:0] c_SRC2 = 2'b10;

    // Both 1x codes address source 2; fold 11 onto 10 so comparisons and the
    // reported selection only ever see the three canonical codes.
    function automatic logic [1:0] normalise_sel(input logic [1:0] sel);
        normalise_sel = (sel == 2'b11) ? c_SRC2 : sel;
    endfunction

endpackage : clk_sw_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Single-bit two-flop synchroniser, asynchronous active-low
//                reset. o_q is the safe synchronised value; o_q_early is the
//                first-stage value, i.e. what o_q will show one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_q_early
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q       = r_sync;
    assign o_q_early = r_meta;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/clk_sw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clk_sw_ctrl
//  Description : Software clock-select control stage in front of the 3-input
//                glitch-free clock mux. Accepts select requests, waits for the
//                target clock to be alive, drives cgm_sel, holds busy across a
//                settle window and optionally falls back to source 0 when the
//                active source 1/2 clock dies.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_sw_ctrl
    import clk_sw_pkg::*;
#(
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 8
) (
    input  logic       clk_in0_scan,
    input  logic       rst_clk_n,
    input  logic       req_vld,
    input  logic [1:0] req_sel,
    output logic       req_rdy,
    input  logic       fallback_en,
    input  logic       clk1_alive_async,
    input  logic       clk2_alive_async,
    output logic [1:0] cgm_sel,
    output logic [1:0] cur_sel,
    output logic       busy,
    output logic       done_pls,
    output logic       err_pls,
    output logic       fb_pls
);

    // Reject parameter sets the shared counter cannot represent
    generate
        if ((SETTLE_CYC < 1) || (TIMEOUT_CYC < 1) ||
            (SETTLE_CYC > (2 ** CNT_W)) || (TIMEOUT_CYC > (2 ** CNT_W))) begin : g_bad_params
            $error("clk_sw_ctrl: SETTLE_CYC/TIMEOUT_CYC must be in 1..2**CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] c_SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE      = CNT_W'(1);

    // ------------------------------------------------------------------
    // Liveness synchronisers (source 0 is our own clock, always alive)
    // ------------------------------------------------------------------
    logic w_alive1;
    logic w_alive1_early;
    logic w_alive2;
    logic w_alive2_early;

    sync_2ff u_sync_clk1 (
        .clk       (clk_in0_scan),
        .rst_n     (rst_clk_n),
        .i_d       (clk1_alive_async),
        .o_q       (w_alive1),
        .o_q_early (w_alive1_early)
    );

    sync_2ff u_sync_clk2 (
        .clk       (clk_in0_scan),
        .rst_n     (rst_clk_n),
        .i_d       (clk2_alive_async),
        .o_q       (w_alive2),
        .o_q_early (w_alive2_early)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    clk_sw_state_e    r_state;
    clk_sw_state_e    w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_tgt;
    logic [1:0]       w_tgt_nxt;
    logic [1:0]       r_cgm_sel;
    logic [1:0]       w_cgm_nxt;
    logic [1:0]       r_cur_sel;
    logic [1:0]       w_cur_nxt;
    logic             r_fb_req;

    // Registered outputs and their next values
    logic             r_req_rdy;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_fb;
    logic             w_rdy_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic             w_fb_nxt;
    logic             w_fb_pred;
    logic             w_nxt_cur_alive;

    logic [1:0]       w_req_tgt;
    logic             w_accept;
    logic             w_tgt_alive;

    assign w_req_tgt = normalise_sel(req_sel);
    assign w_accept  = req_vld & r_req_rdy;

    // Synchronised liveness of the latched switch target
    always_comb begin
        w_tgt_alive = 1'b1;
        case (r_tgt)
            c_SRC1:  w_tgt_alive = w_alive1;
            c_SRC2:  w_tgt_alive = w_alive2;
            default: w_tgt_alive = 1'b1;
        endcase
    end

    // State register plus the datapath it owns
    always_ff @(posedge clk_in0_scan or negedge rst_clk_n) begin
        if (!rst_clk_n) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_tgt     <= c_SRC0;
            r_cgm_sel <= c_SRC0;
            r_cur_sel <= c_SRC0;
            r_fb_req  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_tgt     <= w_tgt_nxt;
            r_cgm_sel <= w_cgm_nxt;
            r_cur_sel <= w_cur_nxt;
            r_fb_req  <= w_fb_pred;
        end
    end

    // Next-state and datapath decisions
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tgt_nxt   = r_tgt;
        w_cgm_nxt   = r_cgm_sel;
        w_cur_nxt   = r_cur_sel;
        case (r_state)
            c_ST_IDLE: begin
                // A pending fallback wins; req_rdy is already low this cycle
                if (r_fb_req) begin
                    w_state_nxt = c_ST_FALLBACK;
                    w_cgm_nxt   = c_SRC0;
                    w_cnt_nxt   = '0;
                end else if (w_accept && (w_req_tgt != r_cur_sel)) begin
                    w_state_nxt = c_ST_CHECK;
                    w_tgt_nxt   = w_req_tgt;
                    w_cnt_nxt   = '0;
                end
            end
            c_ST_CHECK: begin
                if (w_tgt_alive) begin
                    w_state_nxt = c_ST_SETTLE;
                    w_cgm_nxt   = r_tgt;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_ST_SETTLE: begin
                if (r_cnt == c_SETTLE_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cur_nxt   = r_tgt;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_ST_FALLBACK: begin
                if (r_cnt == c_SETTLE_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cur_nxt   = c_SRC0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Output next values: pulses from transitions, handshake from next state.
    // The fallback flag is predicted from the first synchroniser stage so that
    // req_rdy is already low in the very cycle a fallback is about to be taken.
    always_comb begin
        w_nxt_cur_alive = 1'b1;
        case (w_cur_nxt)
            c_SRC1:  w_nxt_cur_alive = w_alive1_early;
            c_SRC2:  w_nxt_cur_alive = w_alive2_early;
            default: w_nxt_cur_alive = 1'b1;
        endcase
        w_fb_pred  = fallback_en && (w_cur_nxt != c_SRC0) && !w_nxt_cur_alive;
        w_rdy_nxt  = (w_state_nxt == c_ST_IDLE) && !w_fb_pred;
        w_busy_nxt = (w_state_nxt != c_ST_IDLE);
        w_done_nxt = ((r_state == c_ST_SETTLE) && (w_state_nxt == c_ST_IDLE)) ||
                     ((r_state == c_ST_IDLE) && !r_fb_req && w_accept &&
                      (w_req_tgt == r_cur_sel));
        w_err_nxt  = (r_state == c_ST_CHECK)    && (w_state_nxt == c_ST_IDLE);
        w_fb_nxt   = (r_state == c_ST_FALLBACK) && (w_state_nxt == c_ST_IDLE);
    end

    // Output registers
    always_ff @(posedge clk_in0_scan or negedge rst_clk_n) begin
        if (!rst_clk_n) begin
            r_req_rdy <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_fb      <= 1'b0;
        end else begin
            r_req_rdy <= w_rdy_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_fb      <= w_fb_nxt;
        end
    end

    assign req_rdy  = r_req_rdy;
    assign busy     = r_busy;
    assign done_pls = r_done;
    assign err_pls  = r_err;
    assign fb_pls   = r_fb;
    assign cgm_sel  = r_cgm_sel;
    assign cur_sel  = r_cur_sel;

endmodule : clk_sw_ctrl
`default_nettype wire
